serial_sub: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/one_bit_sub.sv | 11 +
 rtl/serial_sub.sv | 104 ++++++++++
 tb/tb_serial_sub.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM encoding and sizing helper for the bit-serial arithmetic units.
package serial_arith_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/one_bit_sub.sv
// one_bit_sub: combinational full subtractor cell, e1 - e2 - bin.
module one_bit_sub (
    input  logic e1,
    input  logic e2,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = e1 ^ e2 ^ bin;
    assign bout = (~e1 & e2) | (~(e1 ^ e2) & bin);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: LSB-first bit-serial a - b through one full-subtractor cell, valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state, next;
    logic [WIDTH-1:0] a_sr, b_sr, res;
    logic [CW-1:0]    cnt;
    logic             borrow, d, bo, last, accept;

    one_bit_sub u_cell (
        .e1  (a_sr[0]),
        .e2  (b_sr[0]),
        .bin (borrow),
        .d   (d),
        .bout(bo)
    );

    assign last   = cnt == CW'(WIDTH - 1);
    assign accept = state == IDLE && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = in_valid ? RUN : IDLE;
            RUN:     next = last ? DONE : RUN;
            DONE:    next = out_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // Result bits enter at the MSB so the word is aligned after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res    <= {d, res[WIDTH-1:1]};
            borrow <= bo;
            cnt    <= cnt + CW'(1);
        end
    end

    assign diff = res;
    assign bout = borrow;

`ifdef SERIAL_SUB_OVF_EN
    logic a_s, b_s, ovf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s   <= 1'b0;
            b_s   <= 1'b0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            a_s   <= a[WIDTH-1];
            b_s   <= b[WIDTH-1];
        end else if (state == RUN && last) begin
            ovf_r <= (a_s != b_s) && (d != a_s);
        end
    end

    assign ovf = ovf_r;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed self-checking bench for serial_sub (WIDTH=8).
module tb_serial_sub;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] diff;
    logic       bout;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int failures = 0;

    serial_sub #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic [7:0] ed,
                          input logic eb, input logic eo, input string tag);
        int n;
        a = ta;
        b = tbv;
        in_valid = 1'b1;
        out_ready = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~ta;
        b = ~tbv;
        wait_valid(n);
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo) begin end
`endif
        @(posedge clk);
        #1;
        check({tag, "_after_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_after_ready"}, 32'(in_ready), 32'd1);
    endtask

    logic [7:0] ta, tb2;
    logic       seen, hs;
    int         n, k;

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "d05_03");
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "d03_05");
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "d00_00");
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "d80_01");
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "d7F_FF");

        // Backpressure: hold the result while new operands are offered
        a = 8'h03;
        b = 8'h05;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(n);
        check("bp_latency", 32'(n), 32'd8);
        a = 8'h55;
        b = 8'h22;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_diff", 32'(diff), 32'hFE);
            check("bp_bout", 32'(bout), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a run
        a = 8'hAA;
        b = 8'h11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_bout", 32'(bout), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        check("mid_rst_no_pulse", 32'(seen), 32'd0);
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, "post_rst");

        // Back-to-back with in_valid held high and random out_ready
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ta = 8'($urandom);
            tb2 = 8'($urandom);
            a = ta;
            b = tb2;
            check($sformatf("b2b%0d_in_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            a = 8'($urandom);
            b = 8'($urandom);
            out_ready = 1'b0;
            wait_valid(n);
            check($sformatf("b2b%0d_latency", i), 32'(n), 32'd8);
            check($sformatf("b2b%0d_diff", i), 32'(diff), 32'(8'(ta - tb2)));
            check($sformatf("b2b%0d_bout", i), 32'(bout), 32'(ta < tb2));
            hs = 1'b0;
            k = 0;
            while (!hs && k < 50) begin
                out_ready = 1'($urandom_range(0, 1));
                hs = out_ready;
                @(posedge clk);
                #1;
                k++;
            end
            check($sformatf("b2b%0d_handshake", i), 32'(hs), 32'd1);
            check($sformatf("b2b%0d_out_valid_low", i), 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
